fetch_align_buf: RTL and testbench

Parametrised fetch-alignment buffer between the instruction fetch path and the multi-lane decoder. It accepts aligned fetch blocks of `FETCH_BYTES` carrying mixed 16-/32-bit RISC-V instructions and queues them as halfwords in a circular buffer. Each cycle it presents up to `ISSUE_W` naturally-extracted instructions with their PCs. It replaces the fixed two-lane IFID register plus decoder-side `NextPC` bookkeeping. It adds backpressure, 32-bit instructions straddling fetch blocks, and flush redirect to any halfword-aligned PC.

---
 rtl/fetch_align_buf_pkg.sv | 19 +
 rtl/fetch_align_buf_if.sv | 29 ++
 rtl/fetch_align_buf_lane_extract.sv | 65 ++++++
 rtl/fetch_align_buf.sv | 149 ++++++++++++++
 tb/tb_fetch_align_buf.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_align_buf_pkg.sv
// Shared types and helpers for the fetch alignment buffer and its lane extractor.
// No logic of its own; everything here is used combinationally by the importers.
package fetch_align_buf_pkg;
    localparam int INSTR_W         = 32;
    localparam int HW_W            = 16;
    localparam int DEF_FETCH_BYTES = 8;

    typedef logic [HW_W-1:0] hw_t;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_STREAM = 1'b1
    } fab_state_e;

    // A halfword whose two low bits are not 2'b11 starts a compressed instruction.
    function automatic logic is_rvc(input hw_t hw);
        return hw[1:0] != 2'b11;
    endfunction
endpackage

// File: rtl/fetch_align_buf_if.sv
// Fetch-side, redirect and decoder-side signals of the fetch alignment buffer.
// master = fetch unit / decoder side, slave = the buffer.
interface fetch_align_buf_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_BYTES = fetch_align_buf_pkg::DEF_FETCH_BYTES,
    parameter int ISSUE_W     = 2
);
    logic                                                fetch_valid;
    logic                                                fetch_ready;
    logic [ADDR_WIDTH-1:0]                               fetch_pc;
    logic [8*FETCH_BYTES-1:0]                            fetch_data;
    logic                                                flush;
    logic [ADDR_WIDTH-1:0]                               flush_pc;
    logic [ISSUE_W-1:0]                                  issue_valid;
    logic [ISSUE_W-1:0][fetch_align_buf_pkg::INSTR_W-1:0] issue_instr;
    logic [ISSUE_W-1:0][ADDR_WIDTH-1:0]                  issue_pc;
    logic [ISSUE_W-1:0]                                  issue_16bit;
    logic                                                dec_ready;

    modport master (
        output fetch_valid, fetch_pc, fetch_data, flush, flush_pc, dec_ready,
        input  fetch_ready, issue_valid, issue_instr, issue_pc, issue_16bit
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_data, flush, flush_pc, dec_ready,
        output fetch_ready, issue_valid, issue_instr, issue_pc, issue_16bit
    );
endinterface

// File: rtl/fetch_align_buf_lane_extract.sv
// Splits the halfword window at the buffer head into up to ISSUE_W instructions.
// Purely combinational; a 32-bit instruction missing its high half ends the lane run.
module fab_lane_extract
    import fetch_align_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ISSUE_W    = 2,
    parameter int CNT_W      = 5,
    parameter int USED_W     = $clog2(2*ISSUE_W+1)
) (
    input  hw_t [2*ISSUE_W-1:0]                i_win,
    input  logic [CNT_W-1:0]                   i_count,
    input  logic [ADDR_WIDTH-1:0]              i_head_pc,
    output logic [ISSUE_W-1:0]                 o_valid,
    output logic [ISSUE_W-1:0][INSTR_W-1:0]    o_instr,
    output logic [ISSUE_W-1:0][ADDR_WIDTH-1:0] o_pc,
    output logic [ISSUE_W-1:0]                 o_16bit,
    output logic [USED_W-1:0]                  o_used
);
    localparam int WIN   = 2*ISSUE_W;
    localparam int IDX_W = $clog2(WIN);

    logic [USED_W-1:0] w_avail;

    always_comb begin
        w_avail = (i_count > CNT_W'(WIN)) ? USED_W'(WIN) : USED_W'(i_count);
    end

    always_comb begin
        logic [USED_W-1:0] off;
        logic [USED_W-1:0] off1;
        logic              stop;
        hw_t               lo;
        hw_t               hi;
        off     = '0;
        off1    = '0;
        stop    = 1'b0;
        lo      = '0;
        hi      = '0;
        o_valid = '0;
        o_instr = '0;
        o_pc    = '0;
        o_16bit = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            // Lanes after the last valid one still report the next sequential PC.
            o_pc[k] = i_head_pc + ADDR_WIDTH'({off, 1'b0});
            off1    = off + USED_W'(1);
            lo      = i_win[off[IDX_W-1:0]];
            hi      = i_win[off1[IDX_W-1:0]];
            if (!stop && (off < w_avail) && is_rvc(lo)) begin
                o_valid[k] = 1'b1;
                o_16bit[k] = 1'b1;
                o_instr[k] = {{(INSTR_W-HW_W){1'b0}}, lo};
                off        = off1;
            end else if (!stop && (off1 < w_avail) && !is_rvc(lo)) begin
                o_valid[k] = 1'b1;
                o_instr[k] = {hi, lo};
                off        = off + USED_W'(2);
            end else begin
                stop = 1'b1;
            end
        end
        o_used = off;
    end
endmodule

// File: rtl/fetch_align_buf.sv
// Halfword queue between fetch and decode; fetched data shows on issue lanes one cycle after acceptance.
// fetch_ready drops when a whole block no longer fits (count before dequeue); dec_ready consumes all valid lanes.
module fetch_align_buf
    import fetch_align_buf_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    FETCH_BYTES = DEF_FETCH_BYTES,
    parameter int                    ISSUE_W     = 2,
    parameter int                    DEPTH_HW    = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input logic              clk,
    input logic              rst_n,
    fetch_align_buf_if.slave bus
);
    localparam int FETCH_HW = FETCH_BYTES / 2;
    localparam int BLK_W    = $clog2(FETCH_BYTES);
    localparam int OFF_W    = BLK_W - 1;
    localparam int PTR_W    = $clog2(DEPTH_HW);
    localparam int CNT_W    = PTR_W + 1;
    localparam int WIN      = 2*ISSUE_W;
    localparam int USED_W   = $clog2(WIN+1);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(FETCH_BYTES-1);

    hw_t                   r_buf [DEPTH_HW];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_head_pc;
    logic [ADDR_WIDTH-1:0] r_exp_pc;
    fab_state_e            r_state;
    fab_state_e            w_state_nxt;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_base_match;
    logic                  w_wr_en;
    logic [OFF_W-1:0]      w_skip;
    logic [CNT_W-1:0]      w_wr_num;
    logic [USED_W-1:0]     w_used;
    logic [USED_W-1:0]     w_deq;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    hw_t [WIN-1:0]         w_win;
    logic [ISSUE_W-1:0]    w_lane_vld;

    assign w_ready       = rst_n && (r_count <= CNT_W'(DEPTH_HW - FETCH_HW));
    assign w_accept      = bus.fetch_valid && w_ready && !bus.flush;
    assign w_base_match  = ((bus.fetch_pc ^ r_exp_pc) & BASE_MASK) == '0;
    assign w_redirect_pc = bus.flush_pc & ~ADDR_WIDTH'(1);
    assign w_deq         = (bus.dec_ready && w_lane_vld[0]) ? w_used : '0;
    assign w_wr_num      = CNT_W'(FETCH_HW) - CNT_W'(w_skip);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_SYNC;
        end else if (bus.flush) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A block that misses the expected base is a stale fetch from before a redirect.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_SYNC && w_accept && w_base_match) begin
            w_state_nxt = ST_STREAM;
        end
    end

    always_comb begin
        w_wr_en = 1'b0;
        w_skip  = '0;
        case (r_state)
            ST_SYNC: begin
                w_wr_en = w_accept && w_base_match;
                w_skip  = r_exp_pc[BLK_W-1:1];
            end
            ST_STREAM: begin
                w_wr_en = w_accept;
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_head_pc <= RESET_PC;
            r_exp_pc  <= RESET_PC;
        end else if (bus.flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_head_pc <= w_redirect_pc;
            r_exp_pc  <= w_redirect_pc;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq);
            r_count <= r_count + (w_wr_en ? w_wr_num : '0) - CNT_W'(w_deq);
            if (w_wr_en) begin
                r_tail <= r_tail + PTR_W'(w_wr_num);
            end
            if (w_wr_en && r_state == ST_SYNC && r_count == '0) begin
                r_head_pc <= r_exp_pc;
            end else begin
                r_head_pc <= r_head_pc + ADDR_WIDTH'({w_deq, 1'b0});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < FETCH_HW; i++) begin
                if (OFF_W'(i) >= w_skip) begin
                    r_buf[r_tail + PTR_W'(i) - PTR_W'(w_skip)] <= bus.fetch_data[16*i +: 16];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < WIN; j++) begin
            w_win[j] = r_buf[r_head + PTR_W'(j)];
        end
    end

    fab_lane_extract #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ISSUE_W    (ISSUE_W),
        .CNT_W      (CNT_W),
        .USED_W     (USED_W)
    ) u_lane_extract (
        .i_win      (w_win),
        .i_count    (r_count),
        .i_head_pc  (r_head_pc),
        .o_valid    (w_lane_vld),
        .o_instr    (bus.issue_instr),
        .o_pc       (bus.issue_pc),
        .o_16bit    (bus.issue_16bit),
        .o_used     (w_used)
    );

    assign bus.issue_valid = w_lane_vld;
    assign bus.fetch_ready = w_ready;
endmodule

// File: tb/tb_fetch_align_buf.sv
// Directed bench for fetch_align_buf with hand-computed lane contents.
module tb_fetch_align_buf;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_align_buf_if bus ();

    fetch_align_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] pc, input logic [63:0] d);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        bus.fetch_data  = d;
        step();
        bus.fetch_valid = 1'b0;
    endtask

    task automatic flush_to(input logic [31:0] pc);
        bus.flush    = 1'b1;
        bus.flush_pc = pc;
        step();
        bus.flush    = 1'b0;
    endtask

    task automatic dequeue();
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
    endtask

    // Halfword n of the fill sequence: a distinct compressed instruction.
    function automatic logic [15:0] hw_n(input int n);
        return 16'((n << 2) | 1);
    endfunction

    function automatic logic [63:0] mk_blk(input int b);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = hw_n(4*b + i);
        return r;
    endfunction

    initial begin
        int blk;
        int next_n;
        bit acc;

        rst_n           = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_data  = '0;
        bus.flush       = 1'b0;
        bus.flush_pc    = '0;
        bus.dec_ready   = 1'b0;
        step();
        step();
        chk("rst_valid", bus.issue_valid, 0);
        chk("rst_16bit", bus.issue_16bit, 0);
        chk("rst_instr", bus.issue_instr, 0);
        chk("rst_pc0", bus.issue_pc[0], 0);
        chk("rst_pc1", bus.issue_pc[1], 0);
        chk("rst_ready_low", bus.fetch_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_high", bus.fetch_ready, 1);

        // Two 32-bit instructions.
        fetch_one(32'h0, 64'h00000013_00000013);
        chk("a_valid", bus.issue_valid, 2'b11);
        chk("a_instr0", bus.issue_instr[0], 32'h00000013);
        chk("a_pc0", bus.issue_pc[0], 32'h0);
        chk("a_instr1", bus.issue_instr[1], 32'h00000013);
        chk("a_pc1", bus.issue_pc[1], 32'h4);
        chk("a_16bit", bus.issue_16bit, 2'b00);
        flush_to(32'h0);
        chk("a_flush_valid", bus.issue_valid, 0);

        // Mixed widths, then a partial dequeue.
        fetch_one(32'h0, 64'h57c157c1_00000013);
        chk("b_valid", bus.issue_valid, 2'b11);
        chk("b_instr0", bus.issue_instr[0], 32'h00000013);
        chk("b_instr1", bus.issue_instr[1], 32'h000057c1);
        chk("b_pc1", bus.issue_pc[1], 32'h4);
        chk("b_16bit", bus.issue_16bit, 2'b10);
        dequeue();
        chk("b_deq_valid", bus.issue_valid, 2'b01);
        chk("b_deq_instr0", bus.issue_instr[0], 32'h000057c1);
        chk("b_deq_pc0", bus.issue_pc[0], 32'h6);
        flush_to(32'h0);

        // 32-bit instruction straddling two blocks.
        fetch_one(32'h0, 64'h0093_0001_0001_0001);
        chk("c_valid", bus.issue_valid, 2'b11);
        chk("c_16bit", bus.issue_16bit, 2'b11);
        dequeue();
        chk("c_half_valid", bus.issue_valid, 2'b01);
        chk("c_half_pc0", bus.issue_pc[0], 32'h4);
        dequeue();
        chk("c_wait_valid", bus.issue_valid, 2'b00);
        fetch_one(32'h8, 64'h0001_0001_0001_00A0);
        chk("c_join_valid", bus.issue_valid, 2'b11);
        chk("c_join_instr0", bus.issue_instr[0], 32'h00A00093);
        chk("c_join_pc0", bus.issue_pc[0], 32'h6);
        chk("c_join_16bit", bus.issue_16bit, 2'b10);
        chk("c_join_pc1", bus.issue_pc[1], 32'hA);

        // Redirect to a mid-block PC; bit 0 of the target is ignored.
        flush_to(32'h103);
        chk("d_flush_valid", bus.issue_valid, 0);
        chk("d_flush_pc0", bus.issue_pc[0], 32'h102);
        fetch_one(32'h0, 64'h0001_0001_0001_0001);
        chk("d_stale_valid", bus.issue_valid, 0);
        fetch_one(32'h104, 64'h0005_0009_57c1_1111);
        chk("d_valid", bus.issue_valid, 2'b11);
        chk("d_instr0", bus.issue_instr[0], 32'h000057c1);
        chk("d_pc0", bus.issue_pc[0], 32'h102);
        chk("d_instr1", bus.issue_instr[1], 32'h00000009);
        chk("d_pc1", bus.issue_pc[1], 32'h104);

        // Fill with decoder stalled, then drain while fetching on.
        flush_to(32'h0);
        blk = 0;
        bus.fetch_valid = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.fetch_pc   = 32'(blk * 8);
            bus.fetch_data = mk_blk(blk);
            acc = bus.fetch_ready;
            step();
            if (acc) blk++;
        end
        chk("e_fill_blocks", blk, 4);
        chk("e_fill_ready", bus.fetch_ready, 0);
        next_n = 0;
        bus.dec_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && next_n < 24; cyc++) begin
            bus.fetch_valid = (blk < 6);
            bus.fetch_pc    = 32'(blk * 8);
            bus.fetch_data  = mk_blk(blk);
            acc = bus.fetch_valid && bus.fetch_ready;
            if (bus.issue_valid[0]) begin
                chk("e_lane0_instr", bus.issue_instr[0], {16'h0, hw_n(next_n)});
                chk("e_lane0_pc", bus.issue_pc[0], 32'(2 * next_n));
                next_n++;
                if (bus.issue_valid[1]) begin
                    chk("e_lane1_instr", bus.issue_instr[1], {16'h0, hw_n(next_n)});
                    chk("e_lane1_pc", bus.issue_pc[1], 32'(2 * next_n));
                    next_n++;
                end
            end
            step();
            if (acc) blk++;
        end
        bus.dec_ready   = 1'b0;
        bus.fetch_valid = 1'b0;
        chk("e_drained", next_n, 24);
        chk("e_blocks", blk, 6);
        chk("e_empty_valid", bus.issue_valid, 0);

        // Flush wins over a simultaneous fetch and dequeue.
        fetch_one(32'h30, mk_blk(0));
        chk("f_pre_valid", bus.issue_valid, 2'b11);
        bus.flush       = 1'b1;
        bus.flush_pc    = 32'h200;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h200;
        bus.fetch_data  = 64'h0001_0001_0001_0001;
        bus.dec_ready   = 1'b1;
        step();
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.dec_ready   = 1'b0;
        chk("f_valid", bus.issue_valid, 0);
        chk("f_pc0", bus.issue_pc[0], 32'h200);
        chk("f_pc1", bus.issue_pc[1], 32'h200);
        step();
        chk("f_still_empty", bus.issue_valid, 0);
        fetch_one(32'h200, 64'h0001_0001_0001_0d05);
        chk("f_refill_instr0", bus.issue_instr[0], 32'h00000d05);
        chk("f_refill_pc0", bus.issue_pc[0], 32'h200);

        // Reset mid-operation behaves like a redirect to the reset PC.
        rst_n = 1'b0;
        step();
        chk("g_rst_valid", bus.issue_valid, 0);
        chk("g_rst_pc0", bus.issue_pc[0], 32'h0);
        rst_n = 1'b1;
        fetch_one(32'h0, mk_blk(0));
        chk("g_instr0", bus.issue_instr[0], 32'h00000001);
        chk("g_instr1", bus.issue_instr[1], 32'h00000005);
        chk("g_pc1", bus.issue_pc[1], 32'h2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
